spi_mem_arbiter: RTL and testbench
==================================

Name: spi_mem_arbiter

Overview:
Shares the single SPI memory master port (wr/addr/din in, dout/done/err out) between NREQ independent requesters.
- Round-robin arbitration.
- Issues one transaction at a time and holds the master command stable until completion.
- Routes read data and error status back to the granted requester.
- A watchdog aborts transactions whose done never arrives.
- Sits between client logic and the SPI master, one level above it.

Parameters:
NREQ, 2, number of requesters (2..4)
TIMEOUT, 1024, cycles allowed in WAIT for m_done before abort (≥2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-low (asserted when 0)
req  input  NREQ  per-requester transaction request, level
req_wr  input  NREQ  per-requester 1=write, 0=read
req_addr  input  8*NREQ  per-requester address, requester i at [8i+7:8i]
req_din  input  8*NREQ  per-requester write data, same packing
gnt  output  NREQ  one-hot, high from grant until ack inclusive
ack  output  NREQ  one-hot, one-cycle completion pulse
rdata  output  8  read data for acked requester, valid with ack
rsp_err  output  1  error flag, valid with ack
busy  output  1  high in any state other than IDLE
err_cnt  output  8  saturating count of errored transactions
m_start  output  1  one-cycle command strobe to SPI master
m_wr  output  1  command type to master
m_addr  output  8  command address to master
m_din  output  8  command write data to master
m_dout  input  8  read data from master
m_done  input  1  completion pulse from master
m_err  input  1  error from master, sampled with m_done

Behaviour:
Reset (rst=0, async):
- All outputs 0.
- State IDLE, timer 0.
- last_grant = NREQ-1, so requester 0 has first priority.
- Reset mid-transaction drops it silently: no ack; m_start/m_* forced 0.

FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req bit is 1, select the first set bit searching upward from last_grant+1 with wrap-around.
  - Set gnt one-hot.
  - Latch that requester's wr/addr/din into m_wr/m_addr/m_din.
  - Go to ISSUE. Otherwise stay.
- ISSUE:
  - m_start=1 for exactly this cycle; clear timer; go to WAIT.
- WAIT:
  - m_wr/m_addr/m_din held constant; timer increments each cycle.
  - m_done=1: capture rdata=m_dout (forced 0 when m_wr=1), rsp_err=m_err, then go to RESP.
  - Else if timer==TIMEOUT-1: rdata=0, rsp_err=1, go to RESP.
  - m_done and timeout in the same cycle: m_done wins.
- RESP:
  - ack[grant]=1 for one cycle, with rdata/rsp_err stable.
  - If rsp_err, increment err_cnt, saturating at 255.
  - last_grant <= grant; gnt cleared next cycle; go to IDLE.
- rdata/rsp_err hold their values until the next RESP.

Timing and handshake:
- Latency: req sampled in IDLE at cycle T -> gnt high at T+1 and m_start at T+1 (ISSUE) -> m_done at D -> ack at D+1.
- Minimum idle gap: one IDLE cycle between successive transactions.
- Requester must hold req and its command fields until ack.
- Command is latched at grant, so later field changes have no effect.
- req deasserted early: the transaction still completes and is acked.
- req still high in the cycle after ack: treated as a new request, subject to round-robin, so other pending requesters win first.
- m_done outside WAIT is ignored.
- Timer width is clog2(TIMEOUT+1); it never wraps because it is cleared in ISSUE.

Test Plan:
- Single write: req[0]=1, wr=1, addr=0x10, din=0xA5; master returns m_done at +12 cycles -> one m_start with m_addr=0x10, m_din=0xA5; ack[0] the cycle after m_done; rsp_err=0.
- Read-back: req[1]=1, wr=0, addr=0x10; master drives m_dout=0xA5 with m_done -> ack[1] with rdata=0xA5, gnt[1] high ISSUE through RESP.
- Contention: req=2'b11 held continuously from reset -> grant order 0,1,0,1; each requester gets exactly one of every two transactions; gnt never has two bits set.
- Timeout: TIMEOUT=16, master never asserts m_done -> ack exactly 16 cycles after the WAIT entry cycle; rsp_err=1, rdata=0x00; err_cnt=1.
- Master error, and done/timeout race:
  - m_err=1 with m_done -> rsp_err=1, err_cnt increments.
  - m_done on the timeout cycle -> rsp_err=m_err, rdata=m_dout.
- Async reset asserted mid-WAIT -> all outputs 0 immediately, no ack.
  - After release, req[1] and req[0] both pending -> requester 0 granted first.

Source files
------------

// File: rtl/spi_mem_arbiter.sv
// -----------------------------------------------------------------------------
// spi_mem_arbiter
//
// Shares one SPI memory master command port between NREQ requesters using
// round-robin arbitration. One transaction runs at a time. The command is
// latched at grant and held stable until the master reports completion or
// the watchdog expires. The result is then returned to the granted requester
// with a one-cycle ack.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   req       per-requester request (level)
//   req_wr    per-requester command type, 1 = write
//   req_addr  per-requester address, requester i at [8i+7:8i]
//   req_din   per-requester write data, same packing
//   gnt       one-hot grant, high from grant through ack
//   ack       one-hot one-cycle completion pulse
//   rdata     read data for the acked requester (valid with ack, held after)
//   rsp_err   error flag for the acked requester (valid with ack, held after)
//   busy      high whenever the arbiter is not idle
//   err_cnt   saturating count of errored transactions
//   m_start   one-cycle command strobe to the SPI master
//   m_wr, m_addr, m_din   command to the SPI master
//   m_dout, m_done, m_err response from the SPI master
// -----------------------------------------------------------------------------
module spi_mem_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     req_wr,
    input  logic [8*NREQ-1:0]   req_addr,
    input  logic [8*NREQ-1:0]   req_din,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     ack,
    output logic [7:0]          rdata,
    output logic                rsp_err,
    output logic                busy,
    output logic [7:0]          err_cnt,
    output logic                m_start,
    output logic                m_wr,
    output logic [7:0]          m_addr,
    output logic [7:0]          m_din,
    input  logic [7:0]          m_dout,
    input  logic                m_done,
    input  logic                m_err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [GW-1:0]      sel_q, sel_d;
    logic [GW-1:0]      last_q, last_d;
    logic               m_wr_q, m_wr_d;
    logic [7:0]         m_addr_q, m_addr_d;
    logic [7:0]         m_din_q, m_din_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               rsp_err_q, rsp_err_d;
    logic [7:0]         err_cnt_q, err_cnt_d;

    // Unpacked views of the per-requester command fields
    logic [7:0] addr_a [NREQ];
    logic [7:0] din_a  [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_a[gi] = req_addr[8*gi +: 8];
            assign din_a[gi]  = req_din[8*gi +: 8];
        end
    endgenerate

    // Round-robin pick: nearest set bit above last_q, wrapping around.
    // Offsets are scanned from farthest to nearest so the nearest one wins.
    logic           pick_valid;
    logic [GW-1:0]  pick_idx;

    always_comb begin
        int c;
        pick_valid = 1'b0;
        pick_idx   = '0;
        c          = 0;
        for (int k = NREQ; k >= 1; k--) begin
            c = int'(last_q) + k;
            if (c >= NREQ) begin
                c = c - NREQ;
            end
            if (req[c]) begin
                pick_valid = 1'b1;
                pick_idx   = GW'(c);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        last_d    = last_q;
        m_wr_d    = m_wr_q;
        m_addr_d  = m_addr_q;
        m_din_d   = m_din_q;
        timer_d   = timer_q;
        rdata_d   = rdata_q;
        rsp_err_d = rsp_err_q;
        err_cnt_d = err_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    sel_d           = pick_idx;
                    m_wr_d          = req_wr[pick_idx];
                    m_addr_d        = addr_a[pick_idx];
                    m_din_d         = din_a[pick_idx];
                    state_d         = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                // A completion arriving on the last allowed cycle beats the watchdog
                if (m_done) begin
                    rdata_d   = m_wr_q ? 8'h00 : m_dout;
                    rsp_err_d = m_err;
                    state_d   = S_RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    rdata_d   = 8'h00;
                    rsp_err_d = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_err_q && (err_cnt_q != 8'hFF)) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
                last_d  = sel_q;
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            last_q    <= GW'(NREQ - 1);
            m_wr_q    <= 1'b0;
            m_addr_q  <= 8'h00;
            m_din_q   <= 8'h00;
            timer_q   <= '0;
            rdata_q   <= 8'h00;
            rsp_err_q <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            m_wr_q    <= m_wr_d;
            m_addr_q  <= m_addr_d;
            m_din_q   <= m_din_d;
            timer_q   <= timer_d;
            rdata_q   <= rdata_d;
            rsp_err_q <= rsp_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign ack     = (state_q == S_RESP) ? gnt_q : '0;
    assign rdata   = rdata_q;
    assign rsp_err = rsp_err_q;
    assign busy    = (state_q != S_IDLE);
    assign err_cnt = err_cnt_q;
    assign m_start = (state_q == S_ISSUE);
    assign m_wr    = m_wr_q;
    assign m_addr  = m_addr_q;
    assign m_din   = m_din_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
module tb_spi_mem_arbiter;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     req_wr;
    logic [8*NREQ-1:0]   req_addr;
    logic [8*NREQ-1:0]   req_din;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     ack;
    logic [7:0]          rdata;
    logic                rsp_err;
    logic                busy;
    logic [7:0]          err_cnt;
    logic                m_start;
    logic                m_wr;
    logic [7:0]          m_addr;
    logic [7:0]          m_din;
    logic [7:0]          m_dout;
    logic                m_done;
    logic                m_err;

    int n_vec     = 0;
    int n_miscmp  = 0;

    spi_mem_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_wr   (req_wr),
        .req_addr (req_addr),
        .req_din  (req_din),
        .gnt      (gnt),
        .ack      (ack),
        .rdata    (rdata),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .err_cnt  (err_cnt),
        .m_start  (m_start),
        .m_wr     (m_wr),
        .m_addr   (m_addr),
        .m_din    (m_din),
        .m_dout   (m_dout),
        .m_done   (m_done),
        .m_err    (m_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic wr, input logic [7:0] addr, input logic [7:0] din);
        req_wr[i]          = wr;
        req_addr[8*i +: 8] = addr;
        req_din[8*i +: 8]  = din;
        req[i]             = 1'b1;
    endtask

    // Waits for m_start, then plays the master: m_done is driven on WAIT
    // cycle done_at (0 = WAIT entry cycle; negative = never). Returns at the
    // negedge where ack is seen.
    task automatic run_txn(input int done_at, input logic err_in, input logic [7:0] dout_in,
                           output int lat, output int wcyc,
                           output logic [NREQ-1:0] g_start, output logic [NREQ-1:0] ack_seen,
                           output logic wr_s, output logic [7:0] addr_s, output logic [7:0] din_s);
        lat = -1; wcyc = -1; ack_seen = '0; g_start = '0;
        wr_s = 1'b0; addr_s = 8'h00; din_s = 8'h00;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (m_start) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            chk("m_start_seen", {31'd0, m_start}, 32'd1);
            return;
        end
        g_start = gnt; wr_s = m_wr; addr_s = m_addr; din_s = m_din;
        for (int i = 0; i <= TIMEOUT + 4; i++) begin
            @(negedge clk);
            chk("gnt_onehot", ($countones(gnt) <= 1) ? 32'd1 : 32'd0, 32'd1);
            if (ack != '0) begin
                ack_seen = ack;
                wcyc     = i;
                break;
            end
            chk("m_start_once", {31'd0, m_start}, 32'd0);
            chk("m_addr_held", {24'd0, m_addr}, {24'd0, addr_s});
            if (i == done_at) begin
                m_done = 1'b1; m_err = err_in; m_dout = dout_in;
            end else begin
                m_done = 1'b0; m_err = 1'b0;
            end
        end
        m_done = 1'b0; m_err = 1'b0;
        chk("ack_seen", {31'd0, (ack_seen != '0)}, 32'd1);
    endtask

    int               lat, wcyc;
    logic [NREQ-1:0]  g_s, a_s;
    logic             wr_s;
    logic [7:0]       addr_s, din_s;
    logic [NREQ-1:0]  exp_order [4];

    initial begin
        rst = 1'b0; req = '0; req_wr = '0; req_addr = '0; req_din = '0;
        m_dout = 8'h00; m_done = 1'b0; m_err = 1'b0;
        exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;

        repeat (2) @(negedge clk);
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_ack", {30'd0, ack}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mstart", {31'd0, m_start}, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("rst_cmd", {15'd0, m_wr, m_addr, m_din}, 32'd0);
        rst = 1'b1;

        // Single write: read data forced to 0 even though master drives m_dout
        @(negedge clk);
        set_req(0, 1'b1, 8'h10, 8'hA5);
        run_txn(11, 1'b0, 8'h77, lat, wcyc, g_s, a_s, wr_s, addr_s, din_s);
        $display("txn write: lat=%0d wcyc=%0d gnt=%b ack=%b addr=%h din=%h rdata=%h err=%b",
                 lat, wcyc, g_s, a_s, addr_s, din_s, rdata, rsp_err);
        chk("wr_lat", lat, 1);
        chk("wr_gnt", {30'd0, g_s}, 32'd1);
        chk("wr_cmd", {15'd0, wr_s, addr_s, din_s}, {15'd0, 1'b1, 8'h10, 8'hA5});
        chk("wr_wcyc", wcyc, 12);
        chk("wr_ack", {30'd0, a_s}, 32'd1);
        chk("wr_gnt_at_ack", {30'd0, gnt}, 32'd1);
        chk("wr_rdata", {24'd0, rdata}, 32'd0);
        chk("wr_rsp_err", {31'd0, rsp_err}, 32'd0);
        req = '0;
        @(negedge clk);
        chk("wr_gnt_clr", {30'd0, gnt}, 32'd0);
        chk("wr_idle", {31'd0, busy}, 32'd0);
        chk("wr_ack_pulse", {30'd0, ack}, 32'd0);

        // Read-back by requester 1
        set_req(1, 1'b0, 8'h10, 8'h00);
        run_txn(2, 1'b0, 8'hA5, lat, wcyc, g_s, a_s, wr_s, addr_s, din_s);
        $display("txn read: lat=%0d wcyc=%0d gnt=%b ack=%b rdata=%h err=%b", lat, wcyc, g_s, a_s, rdata, rsp_err);
        chk("rd_gnt", {30'd0, g_s}, 32'd2);
        chk("rd_wr", {31'd0, wr_s}, 32'd0);
        chk("rd_ack", {30'd0, a_s}, 32'd2);
        chk("rd_wcyc", wcyc, 3);
        chk("rd_rdata", {24'd0, rdata}, 32'h000000A5);
        chk("rd_gnt_at_ack", {30'd0, gnt}, 32'd2);
        req = '0;
        @(negedge clk);
        chk("rd_rdata_hold", {24'd0, rdata}, 32'h000000A5);

        // Watchdog: master never answers
        set_req(0, 1'b0, 8'h20, 8'h00);
        run_txn(-1, 1'b0, 8'h00, lat, wcyc, g_s, a_s, wr_s, addr_s, din_s);
        $display("txn timeout: wcyc=%0d ack=%b rdata=%h err=%b", wcyc, a_s, rdata, rsp_err);
        chk("to_wcyc", wcyc, TIMEOUT);
        chk("to_rsp_err", {31'd0, rsp_err}, 32'd1);
        chk("to_rdata", {24'd0, rdata}, 32'd0);
        req = '0;
        @(negedge clk);
        chk("to_err_cnt", {24'd0, err_cnt}, 32'd1);

        // Master error with done
        set_req(1, 1'b0, 8'h30, 8'h00);
        run_txn(0, 1'b1, 8'h5A, lat, wcyc, g_s, a_s, wr_s, addr_s, din_s);
        $display("txn merr: wcyc=%0d ack=%b rdata=%h err=%b", wcyc, a_s, rdata, rsp_err);
        chk("me_ack", {30'd0, a_s}, 32'd2);
        chk("me_rsp_err", {31'd0, rsp_err}, 32'd1);
        chk("me_rdata", {24'd0, rdata}, 32'h0000005A);
        req = '0;
        @(negedge clk);
        chk("me_err_cnt", {24'd0, err_cnt}, 32'd2);

        // Done arrives on the very cycle the watchdog would fire
        set_req(0, 1'b0, 8'h40, 8'h00);
        run_txn(TIMEOUT - 1, 1'b0, 8'h3C, lat, wcyc, g_s, a_s, wr_s, addr_s, din_s);
        $display("txn race: wcyc=%0d ack=%b rdata=%h err=%b", wcyc, a_s, rdata, rsp_err);
        chk("race_wcyc", wcyc, TIMEOUT);
        chk("race_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("race_rdata", {24'd0, rdata}, 32'h0000003C);
        req = '0;
        @(negedge clk);
        chk("race_err_cnt", {24'd0, err_cnt}, 32'd2);

        // Reset in the middle of WAIT
        set_req(0, 1'b1, 8'h50, 8'h11);
        for (int i = 0; i < 8 && !m_start; i++) @(negedge clk);
        chk("mid_m_start", {31'd0, m_start}, 32'd1);
        repeat (3) @(negedge clk);
        chk("mid_busy_before", {31'd0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        $display("txn reset: gnt=%b busy=%b m_start=%b cmd=%b/%h/%h err_cnt=%0d",
                 gnt, busy, m_start, m_wr, m_addr, m_din, err_cnt);
        chk("mid_gnt", {30'd0, gnt}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_cmd", {15'd0, m_wr, m_addr, m_din}, 32'd0);
        chk("mid_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("mid_rdata", {24'd0, rdata}, 32'd0);
        set_req(1, 1'b0, 8'h61, 8'h00);
        set_req(0, 1'b1, 8'h60, 8'hC3);
        repeat (2) begin
            @(negedge clk);
            chk("mid_no_ack", {30'd0, ack}, 32'd0);
        end
        rst = 1'b1;

        // Contention: both requesters held; expect strict alternation from 0
        for (int t = 0; t < 4; t++) begin
            run_txn(1, 1'b0, 8'h00, lat, wcyc, g_s, a_s, wr_s, addr_s, din_s);
            $display("txn contend %0d: lat=%0d gnt=%b ack=%b addr=%h", t, lat, g_s, a_s, addr_s);
            chk("ct_gnt", {30'd0, g_s}, {30'd0, exp_order[t]});
            chk("ct_ack", {30'd0, a_s}, {30'd0, exp_order[t]});
            chk("ct_addr", {24'd0, addr_s}, (exp_order[t] == 2'b01) ? 32'h60 : 32'h61);
            chk("ct_lat", lat, (t == 0) ? 1 : 2);
        end
        req = '0;
        @(negedge clk);
        chk("end_idle", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
